pipe_ctrl: RTL and testbench

Central sequencing controller for the five-stage pipeline registers (F/D, D/E, E/M, M/W) and the PC register. Each cycle it generates enable and synchronous-clear controls for every stage register. Sources are the D-stage data-hazard request, an internal multiply/divide busy counter, and M-stage exception/ERET events. It also drives PC redirection for the exception vector and the EPC return.

---
 rtl/pipe_ctrl.sv | 132 +++++++++++++
 tb/tb_pipe_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stage enable/clear and PC redirect sequencer
module pipe_ctrl #(
  parameter int          MULT_CYC   = 5,
  parameter int          DIV_CYC    = 10,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hz_stall_d,
  input  logic        md_start_e,
  input  logic        md_is_div_e,
  input  logic        md_use_d,
  input  logic        exc_req_m,
  input  logic        eret_m,
  input  logic [31:0] epc_in,
  output logic        pc_en,
  output logic [1:0]  pc_sel,
  output logic [31:0] pc_redirect,
  output logic        en_fd,
  output logic        en_de,
  output logic        en_em,
  output logic        en_mw,
  output logic        clr_fd,
  output logic        clr_de,
  output logic        clr_em,
  output logic        clr_mw,
  output logic        md_busy,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    S_RUN = 2'd0,
    S_MD  = 2'd1
  } state_t;

  localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

  state_t     cur_state;
  state_t     nxt_state;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       stall;

  assign md_busy = (cur_state == S_MD);
  assign state   = cur_state;
  // The issue cycle is covered by md_start_e since md_busy rises only a cycle later.
  assign stall   = hz_stall_d | (md_use_d & (md_busy | md_start_e));

  // State and busy-counter registers; reset aborts any in-flight mult/div.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state <= S_RUN;
      cnt       <= 4'd0;
    end else begin
      cur_state <= nxt_state;
      cnt       <= cnt_nxt;
    end
  end

  // Mult/div sequencing: an issue flushed by an exception never starts, and a
  // running operation is never reloaded or cancelled by flushes.
  always_comb begin
    nxt_state = cur_state;
    cnt_nxt   = cnt;
    case (cur_state)
      S_RUN: begin
        if (md_start_e && !exc_req_m) begin
          nxt_state = S_MD;
          cnt_nxt   = md_is_div_e ? DIV_LD : MULT_LD;
        end
      end
      S_MD: begin
        if (cnt == 4'd1) begin
          nxt_state = S_RUN;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: begin
        nxt_state = S_RUN;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Per-cycle stage controls: reset, then exception > eret > stall > normal.
  always_comb begin
    pc_en       = 1'b1;
    pc_sel      = 2'd0;
    pc_redirect = 32'd0;
    en_fd       = 1'b1;
    en_de       = 1'b1;
    en_em       = 1'b1;
    en_mw       = 1'b1;
    clr_fd      = 1'b0;
    clr_de      = 1'b0;
    clr_em      = 1'b0;
    clr_mw      = 1'b0;
    if (!reset) begin
      pc_en  = 1'b0;
      en_fd  = 1'b0;
      en_de  = 1'b0;
      en_em  = 1'b0;
      en_mw  = 1'b0;
      clr_fd = 1'b1;
      clr_de = 1'b1;
      clr_em = 1'b1;
      clr_mw = 1'b1;
    end else if (exc_req_m) begin
      pc_sel      = 2'd1;
      pc_redirect = EXC_VECTOR;
      clr_fd      = 1'b1;
      clr_de      = 1'b1;
      clr_em      = 1'b1;
      clr_mw      = 1'b1;
    end else if (eret_m) begin
      // The eret itself sits in M and must still retire into W.
      pc_sel      = 2'd2;
      pc_redirect = epc_in;
      clr_fd      = 1'b1;
      clr_de      = 1'b1;
      clr_em      = 1'b1;
    end else if (stall) begin
      pc_en  = 1'b0;
      en_fd  = 1'b0;
      clr_de = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl
module tb_pipe_ctrl;

  localparam logic [31:0] EXC_VEC = 32'h0000_4180;

  typedef struct packed {
    logic        pc_en;
    logic [1:0]  pc_sel;
    logic [31:0] redir;
    logic [3:0]  en;
    logic [3:0]  clr;
    logic        busy;
    logic [1:0]  st;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        hz_stall_d;
  logic        md_start_e;
  logic        md_is_div_e;
  logic        md_use_d;
  logic        exc_req_m;
  logic        eret_m;
  logic [31:0] epc_in;
  logic        pc_en;
  logic [1:0]  pc_sel;
  logic [31:0] pc_redirect;
  logic        en_fd, en_de, en_em, en_mw;
  logic        clr_fd, clr_de, clr_em, clr_mw;
  logic        md_busy;
  logic [1:0]  state;

  exp_t exp_q[$];
  int   errors;
  int   checks;
  int   cycle;
  int   busy_cycles;
  int   stall_cycles;
  int   m_left;

  pipe_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .hz_stall_d  (hz_stall_d),
    .md_start_e  (md_start_e),
    .md_is_div_e (md_is_div_e),
    .md_use_d    (md_use_d),
    .exc_req_m   (exc_req_m),
    .eret_m      (eret_m),
    .epc_in      (epc_in),
    .pc_en       (pc_en),
    .pc_sel      (pc_sel),
    .pc_redirect (pc_redirect),
    .en_fd       (en_fd),
    .en_de       (en_de),
    .en_em       (en_em),
    .en_mw       (en_mw),
    .clr_fd      (clr_fd),
    .clr_de      (clr_de),
    .clr_em      (clr_em),
    .clr_mw      (clr_mw),
    .md_busy     (md_busy),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model_out();
    exp_t e;
    logic busy;
    logic stl;
    busy = (m_left > 0);
    stl  = hz_stall_d | (md_use_d & (busy | md_start_e));
    e.pc_en  = 1'b1;
    e.pc_sel = 2'd0;
    e.redir  = 32'd0;
    e.en     = 4'b1111;
    e.clr    = 4'b0000;
    e.busy   = busy;
    e.st     = busy ? 2'd1 : 2'd0;
    if (!reset) begin
      e.pc_en = 1'b0;
      e.en    = 4'b0000;
      e.clr   = 4'b1111;
      e.busy  = 1'b0;
      e.st    = 2'd0;
    end else if (exc_req_m) begin
      e.pc_sel = 2'd1;
      e.redir  = EXC_VEC;
      e.clr    = 4'b1111;
    end else if (eret_m) begin
      e.pc_sel = 2'd2;
      e.redir  = epc_in;
      e.clr    = 4'b1110;
    end else if (stl) begin
      e.pc_en = 1'b0;
      e.en    = 4'b0111;
      e.clr   = 4'b0100;
    end
    return e;
  endfunction

  // Drives one cycle of inputs, queues the expected outputs, advances the model.
  task automatic step(input logic r, input logic hz, input logic st, input logic dv,
                      input logic use_d, input logic exc, input logic er,
                      input logic [31:0] epc);
    reset       = r;
    hz_stall_d  = hz;
    md_start_e  = st;
    md_is_div_e = dv;
    md_use_d    = use_d;
    exc_req_m   = exc;
    eret_m      = er;
    epc_in      = epc;
    exp_q.push_back(model_out());
    @(posedge clk);
    if (!r)             m_left = 0;
    else if (m_left > 0) m_left = m_left - 1;
    else if (st && !exc) m_left = dv ? 10 : 5;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 32'd0);
  endtask

  // Scoreboard: pop and compare at the falling edge, away from state updates.
  always @(negedge clk) begin
    exp_t a;
    exp_t e;
    cycle = cycle + 1;
    if (md_busy === 1'b1) busy_cycles = busy_cycles + 1;
    if (pc_en === 1'b0 && reset === 1'b1) stall_cycles = stall_cycles + 1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{pc_en, pc_sel, pc_redirect, {en_fd, en_de, en_em, en_mw},
            {clr_fd, clr_de, clr_em, clr_mw}, md_busy, state};
      checks = checks + 1;
      if (a !== e) begin
        errors = errors + 1;
        $display("FAIL scoreboard cycle=%0d actual=%h expected=%h", cycle, a, e);
      end
    end
  end

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 32'd0);
    idle(2);
  endtask

  task automatic test_hazard();
    stall_cycles = 0;
    step(1, 1, 0, 0, 0, 0, 0, 32'd0);
    step(1, 1, 0, 0, 0, 0, 0, 32'd0);
    idle(1);
    checks = checks + 1;
    if (stall_cycles !== 2) begin
      errors = errors + 1;
      $display("FAIL hazard_stall_len actual=%0d expected=2", stall_cycles);
    end
  endtask

  task automatic test_mult();
    busy_cycles  = 0;
    stall_cycles = 0;
    step(1, 0, 1, 0, 1, 0, 0, 32'd0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 1, 0, 0, 32'd0);
    idle(1);
    checks = checks + 1;
    if (busy_cycles !== 5) begin
      errors = errors + 1;
      $display("FAIL mult_busy_len actual=%0d expected=5", busy_cycles);
    end
    checks = checks + 1;
    if (stall_cycles !== 6) begin
      errors = errors + 1;
      $display("FAIL mult_stall_len actual=%0d expected=6", stall_cycles);
    end
  endtask

  task automatic test_div();
    busy_cycles = 0;
    step(1, 0, 1, 1, 0, 0, 0, 32'd0);
    idle(3);
    step(1, 0, 1, 1, 0, 0, 0, 32'd0);
    idle(10);
    checks = checks + 1;
    if (busy_cycles !== 10) begin
      errors = errors + 1;
      $display("FAIL div_busy_len actual=%0d expected=10", busy_cycles);
    end
  endtask

  task automatic test_exc_during_mult();
    busy_cycles = 0;
    step(1, 0, 1, 0, 1, 0, 0, 32'd0);
    step(1, 0, 0, 0, 1, 0, 0, 32'd0);
    step(1, 1, 0, 0, 1, 1, 0, 32'd0);
    step(1, 0, 0, 0, 0, 0, 1, 32'h0000_3010);
    idle(4);
    checks = checks + 1;
    if (busy_cycles !== 5) begin
      errors = errors + 1;
      $display("FAIL exc_mult_busy_len actual=%0d expected=5", busy_cycles);
    end
  endtask

  task automatic test_eret_and_flush_issue();
    busy_cycles = 0;
    step(1, 0, 0, 0, 0, 0, 1, 32'h0000_3010);
    step(1, 0, 0, 0, 0, 1, 1, 32'h0000_3010);
    step(1, 0, 1, 1, 1, 1, 0, 32'd0);
    step(1, 1, 0, 0, 0, 1, 0, 32'd0);
    idle(2);
    checks = checks + 1;
    if (busy_cycles !== 0) begin
      errors = errors + 1;
      $display("FAIL flushed_issue_busy actual=%0d expected=0", busy_cycles);
    end
  endtask

  task automatic test_back_to_back();
    busy_cycles = 0;
    step(1, 0, 1, 0, 0, 0, 0, 32'd0);
    idle(5);
    step(1, 0, 1, 1, 1, 0, 0, 32'd0);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 1, 0, 0, 32'd0);
    idle(1);
    checks = checks + 1;
    if (busy_cycles !== 15) begin
      errors = errors + 1;
      $display("FAIL back_to_back_busy actual=%0d expected=15", busy_cycles);
    end
  endtask

  task automatic test_reset_mid_md();
    step(1, 0, 1, 1, 0, 0, 0, 32'd0);
    idle(2);
    step(0, 0, 0, 0, 0, 0, 0, 32'd0);
    idle(2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      step(1, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
           1'($urandom), 1'($urandom), 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 7) == 0), $urandom);
    end
    idle(12);
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    cycle        = 0;
    busy_cycles  = 0;
    stall_cycles = 0;
    m_left       = 0;
    reset        = 1'b0;
    hz_stall_d   = 1'b0;
    md_start_e   = 1'b0;
    md_is_div_e  = 1'b0;
    md_use_d     = 1'b0;
    exc_req_m    = 1'b0;
    eret_m       = 1'b0;
    epc_in       = 32'd0;
    @(posedge clk);
    #1;
    test_reset();
    test_hazard();
    test_mult();
    test_div();
    test_exc_during_mult();
    test_eret_and_flush_issue();
    test_back_to_back();
    test_reset_mid_md();
    test_random();
    @(negedge clk);
    checks = checks + 1;
    if (exp_q.size() !== 0) begin
      errors = errors + 1;
      $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
